// File: rtl/juggle_scheduler_pkg.sv
// Shared juggling types: scheduler states, landing-queue slot and size constants.
// Used by the pattern-entry, scheduler and render blocks.
package juggle_pkg;

   localparam int unsigned MAX_LEN    = 7;
   localparam int unsigned MAX_HEIGHT = 7;
   localparam int unsigned BALL_W     = 3;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN,
      FAULT
   } sched_state_t;

   typedef struct packed {
      logic              occupied;
      logic [BALL_W-1:0] ball;
   } slot_t;

endpackage

// File: rtl/juggle_scheduler_landing_queue.sv
// Landing queue: one slot per beat ahead, slot 0 lands on the current beat.
// Performs init (balls 0..n-1 in the lowest slots), shift+insert and collision detect.
module landing_queue
   import juggle_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              init,
   input  logic [2:0]        num_balls,
   input  logic              step,
   input  logic [2:0]        height,
   output slot_t             head,
   output logic              collision
);

   slot_t slots   [MAX_HEIGHT];
   slot_t shifted [MAX_HEIGHT];
   slot_t next    [MAX_HEIGHT];

   assign head = slots[0];

   // Queue as it looks one beat later, then the caught ball re-inserted h-1 slots ahead
   always_comb begin
      for (int unsigned k = 0; k < MAX_HEIGHT - 1; k++) begin
         shifted[k] = slots[k+1];
      end
      shifted[MAX_HEIGHT-1] = '0;
      collision = 1'b0;
      for (int unsigned k = 0; k < MAX_HEIGHT; k++) begin
         next[k] = shifted[k];
         if (height != 3'd0 && k == 32'(height) - 1) begin
            next[k] = slots[0];
            if (shifted[k].occupied) begin
               collision = 1'b1;
            end
         end
      end
   end

   // Slot storage: clear, load initial ball placement, or advance one beat
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned k = 0; k < MAX_HEIGHT; k++) begin
            slots[k] <= '0;
         end
      end else if (clear) begin
         for (int unsigned k = 0; k < MAX_HEIGHT; k++) begin
            slots[k] <= '0;
         end
      end else if (init) begin
         for (int unsigned k = 0; k < MAX_HEIGHT; k++) begin
            if (k < 32'(num_balls)) begin
               slots[k] <= '{1'b1, BALL_W'(k)};
            end else begin
               slots[k] <= '0;
            end
         end
      end else if (step) begin
         for (int unsigned k = 0; k < MAX_HEIGHT; k++) begin
            slots[k] <= next[k];
         end
      end
   end

endmodule

// File: rtl/juggle_scheduler.sv
// Siteswap playback scheduler: one throw per beat, tracks balls in flight,
// flags missing balls, drops and collisions.
// Optional JUGGLE_SCHED_STATS_EN adds throw_count_out (beats since LOAD, saturating).
module juggle_scheduler
   import juggle_pkg::*;
(
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         new_beat,
   input  logic [MAX_LEN-1:0][2:0]      pattern_in,
   input  logic [2:0]                   pattern_length,
   input  logic [2:0]                   num_balls_in,
   input  logic                         pattern_valid_in,
   output logic                         throw_valid_out,
   output logic [2:0]                   throw_height_out,
   output logic [BALL_W-1:0]            throw_ball_out,
   output logic                         throw_hand_out,
   output logic [2:0]                   beat_index_out,
   output logic                         running_out,
   output logic                         error_out
`ifdef JUGGLE_SCHED_STATS_EN
   ,
   output logic [15:0]                  throw_count_out
`endif
);

   sched_state_t            state, state_nxt;
   logic                    do_load, do_beat, do_clear;
   logic [MAX_LEN-1:0][2:0] pat_q;
   logic [2:0]              len_q;
   logic [2:0]              index;
   logic                    hand;
   logic [2:0]              height;
   slot_t                   head;
   logic                    collision;
   logic                    violation;

   assign height      = pat_q[index];
   assign violation   = (height != 3'd0 && !head.occupied) ||
                        (height == 3'd0 &&  head.occupied) ||
                        collision;
   assign running_out = (state == RUN);
   assign error_out   = (state == FAULT);

   landing_queue u_queue (
      .clk       (clk_in),
      .rst       (rst_in),
      .clear     (do_clear),
      .init      (do_load),
      .num_balls (num_balls_in),
      .step      (do_beat),
      .height    (height),
      .head      (head),
      .collision (collision)
   );

   // State register
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and per-cycle control; losing pattern_valid_in wins over a beat
   always_comb begin
      state_nxt = state;
      do_load   = 1'b0;
      do_beat   = 1'b0;
      do_clear  = 1'b0;
      case (state)
         IDLE:  if (pattern_valid_in) state_nxt = LOAD;
         LOAD: begin
            do_load   = 1'b1;
            state_nxt = RUN;
         end
         RUN: begin
            if (!pattern_valid_in) begin
               do_clear  = 1'b1;
               state_nxt = IDLE;
            end else if (new_beat) begin
               do_beat = 1'b1;
               if (violation) state_nxt = FAULT;
            end
         end
         FAULT: begin
            if (!pattern_valid_in) begin
               do_clear  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pattern latch, index/hand sequencing and registered throw outputs
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         pat_q            <= '0;
         len_q            <= '0;
         index            <= '0;
         hand             <= 1'b0;
         throw_valid_out  <= 1'b0;
         throw_height_out <= '0;
         throw_ball_out   <= '0;
         throw_hand_out   <= 1'b0;
         beat_index_out   <= '0;
      end else begin
         throw_valid_out <= do_beat;
         if (do_load) begin
            pat_q <= pattern_in;
            len_q <= pattern_length;
            index <= '0;
            hand  <= 1'b0;
         end else if (do_beat) begin
            throw_height_out <= height;
            throw_ball_out   <= (height != 3'd0) ? head.ball : '0;
            throw_hand_out   <= hand;
            beat_index_out   <= index;
            index            <= (index == len_q - 3'd1) ? '0 : index + 3'd1;
            hand             <= ~hand;
         end
      end
   end

`ifdef JUGGLE_SCHED_STATS_EN
   // Executed-beat counter, saturating, restarted by every LOAD
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         throw_count_out <= '0;
      end else if (do_load) begin
         throw_count_out <= '0;
      end else if (do_beat && throw_count_out != 16'hFFFF) begin
         throw_count_out <= throw_count_out + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_juggle_scheduler.sv
// Directed self-checking bench for juggle_scheduler (hand-computed siteswap traces).
module tb_juggle_scheduler;
   import juggle_pkg::*;

   logic                    clk_in = 1'b0;
   logic                    rst_in;
   logic                    new_beat;
   logic [MAX_LEN-1:0][2:0] pattern_in;
   logic [2:0]              pattern_length;
   logic [2:0]              num_balls_in;
   logic                    pattern_valid_in;
   logic                    throw_valid_out;
   logic [2:0]              throw_height_out;
   logic [BALL_W-1:0]       throw_ball_out;
   logic                    throw_hand_out;
   logic [2:0]              beat_index_out;
   logic                    running_out;
   logic                    error_out;
`ifdef JUGGLE_SCHED_STATS_EN
   logic [15:0]             throw_count_out;
`endif

   int checks = 0;
   int errors = 0;

   juggle_scheduler dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .new_beat         (new_beat),
      .pattern_in       (pattern_in),
      .pattern_length   (pattern_length),
      .num_balls_in     (num_balls_in),
      .pattern_valid_in (pattern_valid_in),
      .throw_valid_out  (throw_valid_out),
      .throw_height_out (throw_height_out),
      .throw_ball_out   (throw_ball_out),
      .throw_hand_out   (throw_hand_out),
      .beat_index_out   (beat_index_out),
      .running_out      (running_out),
      .error_out        (error_out)
`ifdef JUGGLE_SCHED_STATS_EN
      ,
      .throw_count_out  (throw_count_out)
`endif
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #500000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Apply a pattern (p0 thrown first) and step through LOAD into RUN
   task automatic load(input logic [2:0] p0, input logic [2:0] p1, input logic [2:0] p2,
                       input logic [2:0] len, input logic [2:0] balls);
      @(negedge clk_in);
      pattern_in       = '0;
      pattern_in[0]    = p0;
      pattern_in[1]    = p1;
      pattern_in[2]    = p2;
      pattern_length   = len;
      num_balls_in     = balls;
      pattern_valid_in = 1'b1;
      @(negedge clk_in);
      @(negedge clk_in);
      // scramble inputs: the latched copy must be unaffected
      pattern_in     = '1;
      pattern_length = 3'd5;
      num_balls_in   = 3'd7;
   endtask

   // One beat strobe; outputs sampled on the following falling edge
   task automatic beat();
      @(negedge clk_in);
      new_beat = 1'b1;
      @(negedge clk_in);
      new_beat = 1'b0;
   endtask

   task automatic beat_expect(input string tag, input int h, input int b, input int hand,
                              input int idx, input int err);
      beat();
      check({tag, ".valid"}, 32'(throw_valid_out), 1);
      check({tag, ".height"}, 32'(throw_height_out), h);
      check({tag, ".ball"}, 32'(throw_ball_out), b);
      check({tag, ".hand"}, 32'(throw_hand_out), hand);
      check({tag, ".index"}, 32'(beat_index_out), idx);
      check({tag, ".error"}, 32'(error_out), err);
   endtask

   task automatic drop_valid();
      @(negedge clk_in);
      pattern_valid_in = 1'b0;
      @(negedge clk_in);
   endtask

   int ball_441 [10] = '{0, 1, 2, 2, 0, 1, 1, 2, 0, 0};
   int h_441    [3]  = '{4, 4, 1};
   int ball_420 [6]  = '{0, 1, 0, 1, 0, 0};
   int h_420    [3]  = '{4, 2, 0};

   initial begin
      rst_in = 1'b1;
      new_beat = 1'b0;
      pattern_in = '0;
      pattern_length = '0;
      num_balls_in = '0;
      pattern_valid_in = 1'b0;
      repeat (2) @(negedge clk_in);
      check("rst.valid", 32'(throw_valid_out), 0);
      check("rst.height", 32'(throw_height_out), 0);
      check("rst.ball", 32'(throw_ball_out), 0);
      check("rst.hand", 32'(throw_hand_out), 0);
      check("rst.index", 32'(beat_index_out), 0);
      check("rst.running", 32'(running_out), 0);
      check("rst.error", 32'(error_out), 0);
      rst_in = 1'b0;

      // beat while idle is ignored
      beat();
      check("idle.beat", 32'(throw_valid_out), 0);

      // cascade "3"
      load(3'd3, 3'd0, 3'd0, 3'd1, 3'd3);
      check("p3.running", 32'(running_out), 1);
      for (int i = 0; i < 7; i++) beat_expect("p3", 3, i % 3, i % 2, 0, 0);
      @(negedge clk_in);
      check("p3.pulse_once", 32'(throw_valid_out), 0);
      drop_valid();
      check("p3.idle", 32'(running_out), 0);

      // "441"
      load(3'd4, 3'd4, 3'd1, 3'd3, 3'd3);
      for (int i = 0; i < 10; i++) beat_expect("p441", h_441[i % 3], ball_441[i], i % 2, i % 3, 0);
      drop_valid();

      // "420": empty-hand beats
      load(3'd4, 3'd2, 3'd0, 3'd3, 3'd2);
      for (int i = 0; i < 6; i++) beat_expect("p420", h_420[i % 3], ball_420[i], i % 2, i % 3, 0);
      drop_valid();

      // "432": collision on beat 1
      load(3'd4, 3'd3, 3'd2, 3'd3, 3'd3);
      beat_expect("p432.b0", 4, 0, 0, 0, 0);
      beat_expect("p432.b1", 3, 1, 1, 1, 1);
      check("p432.running", 32'(running_out), 0);
      beat();
      check("p432.ignored", 32'(throw_valid_out), 0);
      check("p432.sticky", 32'(error_out), 1);
      drop_valid();
      check("p432.cleared", 32'(error_out), 0);

      // asynchronous reset mid-RUN, right after a pulse
      load(3'd3, 3'd0, 3'd0, 3'd1, 3'd3);
      beat_expect("ar", 3, 0, 0, 0, 0);
      #1 rst_in = 1'b1;
      #1;
      check("ar.valid", 32'(throw_valid_out), 0);
      check("ar.height", 32'(throw_height_out), 0);
      check("ar.running", 32'(running_out), 0);
      @(negedge clk_in);
      rst_in = 1'b1;
      pattern_valid_in = 1'b0;
      @(negedge clk_in);
      rst_in = 1'b0;

      // valid dropped on a beat cycle, then restart from LOAD
      load(3'd4, 3'd4, 3'd1, 3'd3, 3'd3);
      beat_expect("vd", 4, 0, 0, 0, 0);
      beat_expect("vd", 4, 1, 1, 1, 0);
      @(negedge clk_in);
      pattern_valid_in = 1'b0;
      new_beat = 1'b1;
      @(negedge clk_in);
      new_beat = 1'b0;
      check("vd.nopulse", 32'(throw_valid_out), 0);
      check("vd.idle", 32'(running_out), 0);
      load(3'd4, 3'd4, 3'd1, 3'd3, 3'd3);
      beat_expect("vd.restart", 4, 0, 0, 0, 0);
      drop_valid();

`ifdef JUGGLE_SCHED_STATS_EN
      load(3'd3, 3'd0, 3'd0, 3'd1, 3'd3);
      for (int i = 0; i < 5; i++) beat();
      check("stats.count", 32'(throw_count_out), 5);
      drop_valid();
      load(3'd3, 3'd0, 3'd0, 3'd1, 3'd3);
      check("stats.reload", 32'(throw_count_out), 0);
      drop_valid();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
